// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter that shares the PIO output register between the CPU store path
// and the LED/counter engine, merging field-masked writes into a shadow PIO word.
module pio_write_arbiter #(
    parameter int          GAP_CYCLES = 0,
    parameter logic [31:0] RST_WORD   = 32'h000000A8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [2:0]  mask0,
    input  logic [31:0] data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [2:0]  mask1,
    input  logic [31:0] data1,
    output logic        ack1,
    output logic        pio_en,
    output logic [31:0] pio_data,
    output logic [31:0] shadow,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, ACK, GAP} state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      state;
    logic        ptr;
    logic        win;
    logic [3:0]  gap_cnt;
    logic        pick1;
    logic [31:0] sel_data;
    logic [31:0] field_mask;
    logic [31:0] merged;

    // Field select: [2]=GPIOf0 bits[31:10], [1]=LED bits[9:2], [0]=counter_set bits[1:0].
    function automatic logic [31:0] expand(input logic [2:0] m);
        return {{22{m[2]}}, {8{m[1]}}, {2{m[0]}}};
    endfunction

    always_comb begin
        pick1      = req1 && (!req0 || ptr);
        sel_data   = pick1 ? data1 : data0;
        field_mask = expand(pick1 ? mask1 : mask0);
        merged     = (shadow & ~field_mask) | (sel_data & field_mask);
    end

    // pio_data doubles as the latched merged word; shadow commits it at the end of ISSUE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            win      <= 1'b0;
            gap_cnt  <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            pio_en   <= 1'b0;
            pio_data <= RST_WORD;
            shadow   <= RST_WORD;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        win      <= pick1;
                        pio_data <= merged;
                        pio_en   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    pio_en <= 1'b0;
                    shadow <= pio_data;
                    ack0   <= !win;
                    ack1   <= win;
                    state  <= ACK;
                end
                ACK: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    ptr  <= !win;
                    if (GAP_CYCLES > 0) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
